// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic             is_div, neg_q, neg_r, dz;
  logic [WIDTH-1:0] opb, acc_hi, acc_lo;

  // Signed ops work on magnitudes; the sign is reapplied in FIX.
  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & rs_data[WIDTH-1];
  assign b_neg     = is_signed & rt_data[WIDTH-1];
  assign a_abs     = a_neg ? (~rs_data + 1'b1) : rs_data;
  assign b_abs     = b_neg ? (~rt_data + 1'b1) : rt_data;

  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign prod_fix  = neg_q ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
  assign quo_fix   = neg_q ? (~acc_lo + 1'b1) : acc_lo;
  assign rem_fix   = neg_r ? (~acc_hi + 1'b1) : acc_hi;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !flush) state_nxt = CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      opb         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !flush) begin
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz     <= op[1] & (rt_data == '0);
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= op[1] ? a_abs : b_abs;
            opb    <= op[1] ? b_abs : a_abs;
          end
        end
        CALC: if (!flush) begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            // Restoring step; a zero divisor always "fits", giving all-ones quotient.
            if (!div_diff[WIDTH]) begin
              acc_hi <= div_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: if (!flush) begin
          done        <= 1'b1;
          div_by_zero <= dz;
          if (is_div) begin
            hi <= rem_fix;
            lo <= dz ? {WIDTH{1'b1}} : quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
